spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
Parametrised SPI master that generalises the fixed 8-bit mode-0 controller. It supports configurable word width, all four CPOL/CPHA modes, a programmable SCLK divider, MSB- or LSB-first ordering and multiple active-low chip selects. It sits between a system-side register/bus interface and the SPI pins. It performs one full-duplex word transfer per start request and signals completion with a done pulse.

Parameters:
DATA_W, 8, transfer word width in bits (>=2)
CS_N, 1, number of chip-select lines
DIV_W, 8, width of clock-divider input
CSW, (CS_N>1 ? $clog2(CS_N) : 1), derived width of chip-select index

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start request; sampled only in IDLE
data_in_bi  in  DATA_W  word to transmit; latched on accepted start
cpol_i  in  1  SCLK idle level; latched on start (also drives idle SCLK)
cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge; latched on start
lsb_first_i  in  1  1: LSB first, 0: MSB first; latched on start
clk_div_bi  in  DIV_W  SCLK half-period = clk_div_bi+1 clk_i cycles; latched on start
cs_sel_bi  in  CSW  index of chip select to assert; latched on start
busy_o  out  1  high while state != IDLE
done_o  out  1  one-cycle pulse on the first IDLE cycle after a transfer
data_out_bo  out  DATA_W  last received word; updated only at transfer end
spi_miso_i  in  1  serial data from slave
spi_mosi_o  out  1  serial data to slave
spi_sclk_o  out  1  serial clock
spi_cs_bo  out  CS_N  active-low chip selects

Behaviour:
- Reset: state IDLE, spi_sclk_o=0, spi_cs_bo all 1, spi_mosi_o=0, busy_o=0, done_o=0, data_out_bo=0, and all internal counters and shift registers cleared. Reset mid-transfer aborts the transfer immediately and produces no done pulse.
- Timebase: a half-period counter reloads with the latched divider and ticks every (div+1) clk_i cycles. With div=0, the half-period is one cycle.
- IDLE state:
  - CS all high, MOSI 0.
  - SCLK registered from live cpol_i (1-cycle lag).
  - start_i=1 latches all config and data_in_bi, then moves to LEAD.
- LEAD state: one half-period.
  - Selected CS low, SCLK = CPOL, MOSI = first bit.
- XFER state: 2*DATA_W half-periods.
  - SCLK toggles at the start of each half-period. Odd-numbered edges (1,3,...) are leading edges; even-numbered edges are trailing edges.
  - SCLK ends at CPOL.
- TRAIL state: one half-period.
  - CS held low, SCLK = CPOL.
  - Then return to IDLE: CS high, done_o=1 for one cycle, data_out_bo loaded from the receive shift register.
- Sampling: MISO is captured on the last clk_i cycle of the half-period that begins with a sampling edge. Sampling edges are leading edges for CPHA=0 and trailing edges for CPHA=1.
- MOSI advance:
  - CPHA=0: advances on each trailing edge except the last.
  - CPHA=1: advances on each leading edge except the first.
- Bit order: lsb_first selects the transmit order and the receive order identically. The received word is assembled so that data_out_bo equals the slave's word in natural bit order.
- Latency: busy_o is high for exactly (2*DATA_W+2)*(div+1) cycles, starting the cycle after the accepting edge.
- start_i while busy is ignored; a new start is not queued.
- start_i in the done_o cycle is accepted (state is IDLE), so back-to-back transfers have one idle cycle between them.
- Input changes during a transfer have no effect; all config is latched at start.
- cs_sel_bi >= CS_N: the transfer runs normally with all CS lines high, done_o still pulses, and data_out_bo is updated.

Test Plan:
1. DATA_W=8, mode 0, div=0, MSB first. Send 0xA5 while the slave model returns 0x3C. Required: MOSI bits 1,0,1,0,0,1,0,1 at leading edges; data_out_bo=0x3C; busy_o high for 18 cycles; one done_o pulse.
2. Mode 3 (cpol=1, cpha=1), div=3, LSB first, send 0x81 with the slave returning 0x7E. Required: SCLK idles at 1 with 4-cycle half-periods; MOSI changes on falling edges; data_out_bo=0x7E; busy_o high for 72 cycles.
3. CS_N=3, cs_sel=2, then cs_sel=3. Required: first transfer drives spi_cs_bo=3'b011 only during busy. Second transfer keeps spi_cs_bo=3'b111 throughout but still pulses done_o.
4. Hold start_i high continuously. Required: transfers repeat, each separated by exactly one IDLE cycle (the done_o cycle). A start pulse mid-transfer changes nothing.
5. Assert rst_i at bit 4 of a transfer. Required: next cycle spi_cs_bo all 1, SCLK 0, busy_o 0, data_out_bo 0, and no done_o pulse.
6. DATA_W=16, mode 1, div=1, send 0xBEEF with loopback (MISO tied to MOSI). Required: data_out_bo=0xBEEF and 32 SCLK edges observed.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// Parametrised SPI master. It runs one full-duplex word transfer per accepted
// start and supports:
//   - all four CPOL/CPHA modes
//   - a programmable SCLK half-period of (clk_div_bi+1) clk_i cycles
//   - MSB- or LSB-first bit order
//   - CS_N active-low chip selects
// Mode, order, divider, chip select and transmit word are latched when start
// is accepted, so input changes during a transfer have no effect.
//
// Ports:
//   clk_i, rst_i       system clock, synchronous active-high reset
//   start_i            start request, sampled only while idle
//   data_in_bi         word to transmit
//   cpol_i, cpha_i     SPI mode; cpol_i also sets the idle SCLK level
//   lsb_first_i        1: LSB first, 0: MSB first (transmit and receive)
//   clk_div_bi         SCLK half-period minus one, in clk_i cycles
//   cs_sel_bi          index of chip select to assert (>= CS_N: none)
//   busy_o             high while a transfer is in progress
//   done_o             one-cycle pulse on the first idle cycle after a transfer
//   data_out_bo        last received word, updated at transfer end
//   spi_miso_i         serial data in
//   spi_mosi_o         serial data out
//   spi_sclk_o         serial clock
//   spi_cs_bo          active-low chip selects
module spi_master_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CS_N   = 1,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned CSW    = (CS_N > 1) ? $clog2(CS_N) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_in_bi,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
    input  logic [DIV_W-1:0]  clk_div_bi,
    input  logic [CSW-1:0]    cs_sel_bi,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] data_out_bo,
    input  logic              spi_miso_i,
    output logic              spi_mosi_o,
    output logic              spi_sclk_o,
    output logic [CS_N-1:0]   spi_cs_bo
);

    // XFER spans 2*DATA_W half-periods, indexed 0 .. 2*DATA_W-1.
    localparam int unsigned     ECW      = $clog2(2 * DATA_W);
    localparam logic [ECW-1:0]  LAST_HP  = ECW'(2 * DATA_W - 1);
    localparam logic [ECW-1:0]  PENULT_HP = ECW'(2 * DATA_W - 2);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t              state;
    logic                cpha_q;
    logic                lsb_q;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    hp_cnt;
    logic [ECW-1:0]      hp_idx;
    logic [DATA_W-1:0]   tx_sr;
    logic [DATA_W-1:0]   rx_sr;

    logic [CS_N-1:0]     cs_start;
    logic                tick;
    logic                sample;
    logic                advance;
    logic                tx_first;
    logic                tx_next;

    // Chip-select pattern for the requested index; out-of-range leaves all high.
    always_comb begin
        cs_start = '1;
        for (int unsigned i = 0; i < CS_N; i++) begin
            if (cs_sel_bi == CSW'(i)) begin
                cs_start[i] = 1'b0;
            end
        end
    end

    assign tick     = (hp_cnt == '0);
    assign tx_first = lsb_first_i ? data_in_bi[0] : data_in_bi[DATA_W-1];
    assign tx_next  = lsb_q ? tx_sr[0] : tx_sr[DATA_W-1];

    // Half-period hp_idx starts with SCLK edge hp_idx+1; even indices follow
    // leading edges. The sampling half-periods are even for CPHA=0, odd for CPHA=1.
    assign sample = (hp_idx[0] == cpha_q);

    // MOSI moves with the edge that opens the next half-period:
    // CPHA=0 on trailing edges except the last, CPHA=1 on leading edges except the first.
    assign advance = (hp_idx != LAST_HP) &&
                     (cpha_q ? hp_idx[0] : (!hp_idx[0] && (hp_idx != PENULT_HP)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            div_q       <= '0;
            hp_cnt      <= '0;
            hp_idx      <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            data_out_bo <= '0;
            spi_mosi_o  <= 1'b0;
            spi_sclk_o  <= 1'b0;
            spi_cs_bo   <= '1;
        end else begin
            case (state)
                IDLE: begin
                    done_o     <= 1'b0;
                    spi_cs_bo  <= '1;
                    spi_mosi_o <= 1'b0;
                    spi_sclk_o <= cpol_i;
                    if (start_i) begin
                        state      <= LEAD;
                        busy_o     <= 1'b1;
                        cpha_q     <= cpha_i;
                        lsb_q      <= lsb_first_i;
                        div_q      <= clk_div_bi;
                        hp_cnt     <= clk_div_bi;
                        hp_idx     <= '0;
                        rx_sr      <= '0;
                        spi_cs_bo  <= cs_start;
                        spi_mosi_o <= tx_first;
                        tx_sr      <= lsb_first_i ? (data_in_bi >> 1) : (data_in_bi << 1);
                    end
                end
                LEAD: begin
                    if (tick) begin
                        state      <= XFER;
                        hp_cnt     <= div_q;
                        spi_sclk_o <= ~spi_sclk_o;
                    end else begin
                        hp_cnt <= hp_cnt - 1'b1;
                    end
                end
                XFER: begin
                    if (tick) begin
                        hp_cnt <= div_q;
                        if (sample) begin
                            rx_sr <= lsb_q ? {spi_miso_i, rx_sr[DATA_W-1:1]}
                                           : {rx_sr[DATA_W-2:0], spi_miso_i};
                        end
                        if (hp_idx == LAST_HP) begin
                            state <= TRAIL;
                        end else begin
                            hp_idx     <= hp_idx + 1'b1;
                            spi_sclk_o <= ~spi_sclk_o;
                        end
                        if (advance) begin
                            spi_mosi_o <= tx_next;
                            tx_sr      <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
                        end
                    end else begin
                        hp_cnt <= hp_cnt - 1'b1;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        spi_cs_bo   <= '1;
                        spi_mosi_o  <= 1'b0;
                        data_out_bo <= rx_sr;
                    end else begin
                        hp_cnt <= hp_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl
// Directed bench for spi_master_ctrl. Two instances are used:
//   - an 8-bit master with three chip selects, driven from a vector table plus
//     hand-written held-start and mid-transfer reset sequences
//   - a 16-bit master in loopback (MISO tied to MOSI)
// A pin-level slave model drives MISO and captures MOSI on sampling edges.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit, three chip selects
    logic       start8 = 1'b0;
    logic [7:0] din8   = '0;
    logic       cpol8  = 1'b0;
    logic       cpha8  = 1'b0;
    logic       lsb8   = 1'b0;
    logic [7:0] div8   = '0;
    logic [1:0] sel8   = '0;
    logic       busy8, done8, mosi8, sclk8;
    logic [7:0] dout8;
    logic [2:0] cs8;
    logic       miso8;

    spi_master_ctrl #(.DATA_W(8), .CS_N(3), .DIV_W(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .data_in_bi(din8),
        .cpol_i(cpol8), .cpha_i(cpha8), .lsb_first_i(lsb8), .clk_div_bi(div8),
        .cs_sel_bi(sel8), .busy_o(busy8), .done_o(done8), .data_out_bo(dout8),
        .spi_miso_i(miso8), .spi_mosi_o(mosi8), .spi_sclk_o(sclk8), .spi_cs_bo(cs8)
    );

    // 16-bit loopback, mode 1, div 1
    logic        start16 = 1'b0;
    logic        busy16, done16, mosi16, sclk16, miso16;
    logic [15:0] dout16;
    logic [0:0]  cs16;
    assign miso16 = mosi16;

    spi_master_ctrl #(.DATA_W(16), .CS_N(1), .DIV_W(8)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .data_in_bi(16'hBEEF),
        .cpol_i(1'b0), .cpha_i(1'b1), .lsb_first_i(1'b0), .clk_div_bi(8'd1),
        .cs_sel_bi(1'b0), .busy_o(busy16), .done_o(done16), .data_out_bo(dout16),
        .spi_miso_i(miso16), .spi_mosi_o(mosi16), .spi_sclk_o(sclk16), .spi_cs_bo(cs16)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave-model configuration for the current 8-bit transfer
    logic       mon_clr  = 1'b0;
    logic       m_cpol   = 1'b0;
    logic       m_cpha   = 1'b0;
    logic       m_lsb    = 1'b0;
    logic [7:0] m_div    = '0;
    logic [7:0] m_slave  = '0;
    logic [2:0] m_exp_cs = 3'b111;

    // Observations, written only by the monitor
    int         busy_cyc, done_cnt, edge_tot, xfer_edges, since_edge;
    int         hp_bad, mosi_bad, cs_bad, nbits;
    logic [7:0] mosi_word;
    logic [2:0] cs_seen;
    logic       prev_sclk, prev_mosi, prev_busy;

    always @(negedge clk) begin : mon8
        logic edge_now, lead;
        int   idx, pos;
        edge_now = busy8 && prev_busy && (sclk8 != prev_sclk);
        lead     = (sclk8 != m_cpol);
        if (mon_clr) begin
            busy_cyc = 0; done_cnt = 0; edge_tot = 0; xfer_edges = 0; since_edge = 0;
            hp_bad = 0; mosi_bad = 0; cs_bad = 0; nbits = 0;
            mosi_word = '0; cs_seen = 3'b111;
        end else begin
            if (busy8) begin
                busy_cyc++;
                cs_seen = cs8;
                if (cs8 != m_exp_cs) cs_bad++;
            end else if (cs8 != 3'b111) begin
                cs_bad++;
            end
            if (done8) done_cnt++;
            if (!busy8) begin
                xfer_edges = 0;
                since_edge = 0;
            end else if (!prev_busy) begin
                since_edge = 1;
            end else if (edge_now) begin
                if (since_edge != int'(m_div) + 1) hp_bad++;
                since_edge = 1;
                xfer_edges++;
                edge_tot++;
                if (lead != m_cpha) begin
                    pos = m_lsb ? nbits : 7 - nbits;
                    if (nbits < 8) mosi_word[pos] = mosi8;
                    nbits++;
                end
            end else begin
                since_edge++;
            end
            if (busy8 && prev_busy && (mosi8 != prev_mosi) && !(edge_now && (lead == m_cpha)))
                mosi_bad++;
        end
        // Slave shifts out its next bit on the edge opposite to the sampling edge
        if (m_cpha) idx = (xfer_edges == 0) ? 0 : (xfer_edges - 1) / 2;
        else        idx = xfer_edges / 2;
        if (idx > 7) idx = 7;
        miso8     = m_lsb ? m_slave[idx] : m_slave[7 - idx];
        prev_sclk = sclk8;
        prev_mosi = mosi8;
        prev_busy = busy8;
    end

    int   busy16_cyc, edges16, done16_cnt;
    logic pb16, ps16;

    always @(negedge clk) begin : mon16
        if (mon_clr) begin
            busy16_cyc = 0; edges16 = 0; done16_cnt = 0;
        end else begin
            if (busy16) busy16_cyc++;
            if (busy16 && pb16 && (sclk16 != ps16)) edges16++;
            if (done16) done16_cnt++;
        end
        pb16 = busy16;
        ps16 = sclk16;
    end

    typedef struct {
        logic       cpol, cpha, lsb;
        logic [7:0] div;
        logic [1:0] sel;
        logic [7:0] tx, slave;
        logic [2:0] exp_cs;
        int         exp_busy;
        logic       mid;
    } vec_t;

    vec_t vecs[5];

    task automatic clear_mon();
        @(posedge clk);
        mon_clr = 1'b1;
        @(posedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic apply_cfg(input vec_t v);
        m_cpol = v.cpol; m_cpha = v.cpha; m_lsb = v.lsb; m_div = v.div;
        m_slave = v.slave; m_exp_cs = v.exp_cs;
        cpol8 = v.cpol; cpha8 = v.cpha; lsb8 = v.lsb; div8 = v.div;
        sel8 = v.sel; din8 = v.tx;
    endtask

    task automatic wait_done8(input string nm, output logic got);
        got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done8) begin
                got = 1'b1;
                break;
            end
        end
        chk({nm, " done seen"}, 32'(got), 32'd1);
    endtask

    task automatic run_vec(input int vi);
        vec_t  v;
        logic  got;
        string p;
        v = vecs[vi];
        p = $sformatf("v%0d", vi);
        clear_mon();
        @(negedge clk);
        apply_cfg(v);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        if (v.mid) begin
            // Restart request and config changes in the middle of a transfer
            repeat (5) @(negedge clk);
            start8 = 1'b1;
            din8 = ~v.tx; cpol8 = ~v.cpol; cpha8 = ~v.cpha; lsb8 = ~v.lsb;
            div8 = '0; sel8 = v.sel + 2'd1;
            @(negedge clk);
            start8 = 1'b0;
        end
        wait_done8(p, got);
        apply_cfg(v);
        repeat (6) @(negedge clk);
        chk({p, " data_out"}, 32'(dout8), 32'(v.slave));
        chk({p, " busy cycles"}, 32'(busy_cyc), 32'(v.exp_busy));
        chk({p, " done pulses"}, 32'(done_cnt), 32'd1);
        chk({p, " sclk edges"}, 32'(edge_tot), 32'd16);
        chk({p, " mosi word"}, 32'(mosi_word), 32'(v.tx));
        chk({p, " mosi off-edge changes"}, 32'(mosi_bad), 32'd0);
        chk({p, " half-period errors"}, 32'(hp_bad), 32'd0);
        chk({p, " cs errors"}, 32'(cs_bad), 32'd0);
        chk({p, " cs during busy"}, 32'(cs_seen), 32'(v.exp_cs));
        chk({p, " idle sclk"}, 32'(sclk8), 32'(v.cpol));
        chk({p, " busy after"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        logic got;
        vec_t hv;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy8), 32'd0);
        chk("rst done", 32'(done8), 32'd0);
        chk("rst cs", 32'(cs8), 32'h7);
        chk("rst sclk", 32'(sclk8), 32'd0);
        chk("rst mosi", 32'(mosi8), 32'd0);
        chk("rst data_out", 32'(dout8), 32'd0);
        rst = 1'b0;

        //        cpol  cpha  lsb   div   sel   tx     slave  cs       busy     mid
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'hA5, 8'h3C, 3'b110, 18 * 1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'd3, 2'd0, 8'h81, 8'h7E, 3'b110, 18 * 4, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'd1, 2'd2, 8'h5A, 8'hC3, 3'b011, 18 * 2, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 8'd2, 2'd3, 8'h3C, 8'h96, 3'b111, 18 * 3, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 8'h0F, 8'hF0, 3'b101, 18 * 2, 1'b1};

        for (int vi = 0; vi < 5; vi++) run_vec(vi);

        // start_i held high: back-to-back transfers with exactly one idle (done) cycle
        clear_mon();
        @(negedge clk);
        apply_cfg(vecs[0]);
        start8 = 1'b1;
        for (int t = 0; t < 3; t++) begin
            wait_done8($sformatf("held%0d", t), got);
            chk($sformatf("held%0d busy at done", t), 32'(busy8), 32'd0);
            chk($sformatf("held%0d data_out", t), 32'(dout8), 32'h3C);
            @(negedge clk);
            chk($sformatf("held%0d busy after done", t), 32'(busy8), 32'd1);
        end
        start8 = 1'b0;
        wait_done8("held end", got);
        repeat (4) @(negedge clk);
        chk("held done pulses", 32'(done_cnt), 32'd4);

        // Reset during bit 4 of a mode-2 transfer
        hv = '{1'b1, 1'b0, 1'b0, 8'd1, 2'd0, 8'h55, 8'h99, 3'b110, 36, 1'b0};
        clear_mon();
        @(negedge clk);
        apply_cfg(hv);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (xfer_edges >= 8) begin
                got = 1'b1;
                break;
            end
        end
        chk("rstmid reached bit 4", 32'(got), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid cs", 32'(cs8), 32'h7);
        chk("rstmid sclk", 32'(sclk8), 32'd0);
        chk("rstmid busy", 32'(busy8), 32'd0);
        chk("rstmid data_out", 32'(dout8), 32'd0);
        chk("rstmid done", 32'(done8), 32'd0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("rstmid done pulses", 32'(done_cnt), 32'd0);
        chk("rstmid busy later", 32'(busy8), 32'd0);

        // 16-bit loopback
        clear_mon();
        @(negedge clk);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done16) begin
                got = 1'b1;
                break;
            end
        end
        chk("lb16 done seen", 32'(got), 32'd1);
        repeat (4) @(negedge clk);
        chk("lb16 data_out", 32'(dout16), 32'hBEEF);
        chk("lb16 sclk edges", 32'(edges16), 32'd32);
        chk("lb16 busy cycles", 32'(busy16_cyc), 32'd68);
        chk("lb16 done pulses", 32'(done16_cnt), 32'd1);
        chk("lb16 cs idle", 32'(cs16), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
